// File: rtl/game_sequencer.sv
// ----------------------------------------------------------------------------
// game_sequencer
//
// Top-level game controller for the player/invader datapath.
// - Owns the game state machine: IDLE, PLAYING, RESPAWN, GAME_OVER.
// - Produces the enable and movement strobes that pace the ship, bullet and
//   invader blocks.
// - Keeps score, remaining lives and wave level.
//
// Parameters
//   TICK_DIV       clock cycles per game tick (>= 2)
//   INV_BASE       game ticks per invader step at level 0 (>= 2)
//   RESPAWN_TICKS  game ticks spent in RESPAWN (>= 1)
//   LIVES          lives at game start (1..3)
//   SCORE_W        score width
//
// Ports
//   i_clk_36MHz         system clock
//   i_reset             synchronous active-high reset
//   i_start_debounced   one-cycle start pulse
//   i_hit               one-cycle pulse: player bullet hit an invader
//   i_ship_hit          one-cycle pulse: invader shot hit the ship
//   i_invaders_cleared  level: no invaders remain
//   i_invaders_landed   level: invaders reached the ship row
//   o_state             0 IDLE, 1 PLAYING, 2 RESPAWN, 3 GAME_OVER
//   o_enable            ship/bullet enable, high only in PLAYING
//   o_bullet_tick       one-cycle bullet step strobe (one per game tick)
//   o_invader_tick      one-cycle invader step strobe
//   o_wave_start        one-cycle pulse: reload invader formation
//   o_clear_score       one-cycle pulse on game start
//   o_score             current score (saturating)
//   o_lives             remaining lives
//   o_level             wave level (saturating at 15)
//
// Every output comes straight from a flop, so an input event at cycle n is
// visible at cycle n+1.
// ----------------------------------------------------------------------------
module game_sequencer #(
   parameter int TICK_DIV      = 3600000,
   parameter int INV_BASE      = 8,
   parameter int RESPAWN_TICKS = 20,
   parameter int LIVES         = 3,
   parameter int SCORE_W       = 8
) (
   input  logic               i_clk_36MHz,
   input  logic               i_reset,
   input  logic               i_start_debounced,
   input  logic               i_hit,
   input  logic               i_ship_hit,
   input  logic               i_invaders_cleared,
   input  logic               i_invaders_landed,
   output logic [1:0]         o_state,
   output logic               o_enable,
   output logic               o_bullet_tick,
   output logic               o_invader_tick,
   output logic               o_wave_start,
   output logic               o_clear_score,
   output logic [SCORE_W-1:0] o_score,
   output logic [1:0]         o_lives,
   output logic [3:0]         o_level
);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_PLAYING   = 2'd1;
   localparam logic [1:0] ST_RESPAWN   = 2'd2;
   localparam logic [1:0] ST_GAME_OVER = 2'd3;

   localparam int TICK_W      = $clog2(TICK_DIV);
   localparam int INV_W       = $clog2(INV_BASE);
   localparam int RESP_CYCLES = RESPAWN_TICKS * TICK_DIV;
   localparam int RESP_W      = $clog2(RESP_CYCLES);

   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);
   localparam logic [RESP_W-1:0]  RESP_LAST  = RESP_W'(RESP_CYCLES - 1);
   localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
   localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
   localparam logic [3:0]         LEVEL_MAX  = 4'd15;

   // Registered state
   logic [1:0]         state_q,        state_d;
   logic               enable_q,       enable_d;
   logic               bullet_tick_q,  bullet_tick_d;
   logic               invader_tick_q, invader_tick_d;
   logic               wave_start_q,   wave_start_d;
   logic               clear_score_q,  clear_score_d;
   logic [SCORE_W-1:0] score_q,        score_d;
   logic [1:0]         lives_q,        lives_d;
   logic [3:0]         level_q,        level_d;
   logic [TICK_W-1:0]  tick_cnt_q,     tick_cnt_d;
   logic [INV_W-1:0]   inv_cnt_q,      inv_cnt_d;
   logic [RESP_W-1:0]  resp_cnt_q,     resp_cnt_d;
   // Remembers that RESPAWN was entered by clearing the wave, so the
   // formation is reloaded when play resumes.
   logic               reload_q,       reload_d;

   logic               game_tick;
   logic [INV_W-1:0]   inv_last;

   // Last invader-counter value of an invader period:
   // P - 1 where P = max(1, INV_BASE - level).
   always_comb begin
      if (int'(level_q) >= INV_BASE - 1) begin
         inv_last = '0;
      end else begin
         inv_last = INV_W'(INV_BASE - 1 - int'(level_q));
      end
   end

   assign game_tick = (state_q == ST_PLAYING) && (tick_cnt_q == TICK_LAST);

   always_comb begin
      state_d        = state_q;
      score_d        = score_q;
      lives_d        = lives_q;
      level_d        = level_q;
      tick_cnt_d     = tick_cnt_q;
      inv_cnt_d      = inv_cnt_q;
      resp_cnt_d     = resp_cnt_q;
      reload_d       = reload_q;
      bullet_tick_d  = 1'b0;
      invader_tick_d = 1'b0;
      wave_start_d   = 1'b0;
      clear_score_d  = 1'b0;

      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (i_start_debounced) begin
               state_d       = ST_PLAYING;
               score_d       = '0;
               lives_d       = LIVES_INIT;
               level_d       = '0;
               clear_score_d = 1'b1;
               wave_start_d  = 1'b1;
               tick_cnt_d    = '0;
               inv_cnt_d     = '0;
               resp_cnt_d    = '0;
               reload_d      = 1'b0;
            end
         end

         ST_PLAYING: begin
            // Scoring is independent of the transition chosen below, so a
            // hit on the same cycle as a state change still counts.
            if (i_hit && (score_q != SCORE_MAX)) begin
               score_d = score_q + 1'b1;
            end

            if (i_invaders_landed) begin
               state_d = ST_GAME_OVER;
            end else if (i_ship_hit) begin
               lives_d = lives_q - 2'd1;
               if (lives_q == 2'd1) begin
                  state_d = ST_GAME_OVER;
               end else begin
                  state_d    = ST_RESPAWN;
                  resp_cnt_d = '0;
                  reload_d   = 1'b0;
               end
            end else if (i_invaders_cleared) begin
               if (level_q != LEVEL_MAX) begin
                  level_d = level_q + 4'd1;
               end
               state_d    = ST_RESPAWN;
               resp_cnt_d = '0;
               reload_d   = 1'b1;
            end else begin
               // Strobes are only issued while play continues, so none can
               // leak into the first cycle of RESPAWN or GAME_OVER.
               if (game_tick) begin
                  tick_cnt_d    = '0;
                  bullet_tick_d = 1'b1;
                  if (inv_cnt_q >= inv_last) begin
                     inv_cnt_d      = '0;
                     invader_tick_d = 1'b1;
                  end else begin
                     inv_cnt_d = inv_cnt_q + 1'b1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 1'b1;
               end
            end
         end

         ST_RESPAWN: begin
            if (resp_cnt_q == RESP_LAST) begin
               state_d      = ST_PLAYING;
               wave_start_d = reload_q;
               reload_d     = 1'b0;
               tick_cnt_d   = '0;
               inv_cnt_d    = '0;
            end else begin
               resp_cnt_d = resp_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Registered decode of the next state keeps o_enable aligned with
      // o_state without a combinational path on the output.
      enable_d = (state_d == ST_PLAYING);
   end

   always_ff @(posedge i_clk_36MHz) begin
      if (i_reset) begin
         state_q        <= ST_IDLE;
         enable_q       <= 1'b0;
         bullet_tick_q  <= 1'b0;
         invader_tick_q <= 1'b0;
         wave_start_q   <= 1'b0;
         clear_score_q  <= 1'b0;
         score_q        <= '0;
         lives_q        <= LIVES_INIT;
         level_q        <= '0;
         tick_cnt_q     <= '0;
         inv_cnt_q      <= '0;
         resp_cnt_q     <= '0;
         reload_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         enable_q       <= enable_d;
         bullet_tick_q  <= bullet_tick_d;
         invader_tick_q <= invader_tick_d;
         wave_start_q   <= wave_start_d;
         clear_score_q  <= clear_score_d;
         score_q        <= score_d;
         lives_q        <= lives_d;
         level_q        <= level_d;
         tick_cnt_q     <= tick_cnt_d;
         inv_cnt_q      <= inv_cnt_d;
         resp_cnt_q     <= resp_cnt_d;
         reload_q       <= reload_d;
      end
   end

   assign o_state        = state_q;
   assign o_enable       = enable_q;
   assign o_bullet_tick  = bullet_tick_q;
   assign o_invader_tick = invader_tick_q;
   assign o_wave_start   = wave_start_q;
   assign o_clear_score  = clear_score_q;
   assign o_score        = score_q;
   assign o_lives        = lives_q;
   assign o_level        = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// ----------------------------------------------------------------------------
// tb_game_sequencer
//
// Bench for game_sequencer with TICK_DIV=4, INV_BASE=3, RESPAWN_TICKS=2,
// LIVES=2, SCORE_W=3. The reference model tracks the game from cycle
// timestamps: strobes are derived from the distance to the cycle play last
// resumed, respawn exit from the distance to the cycle RESPAWN was entered.
// ----------------------------------------------------------------------------
module tb_game_sequencer;

   localparam int T    = 4;
   localparam int IB   = 3;
   localparam int RT   = 2;
   localparam int LV   = 2;
   localparam int SW   = 3;
   localparam int SMAX = (1 << SW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, start, hit, ship, cleared, landed;
   logic [1:0]    o_state;
   logic          o_enable, o_bullet_tick, o_invader_tick, o_wave_start, o_clear_score;
   logic [SW-1:0] o_score;
   logic [1:0]    o_lives;
   logic [3:0]    o_level;

   game_sequencer #(
      .TICK_DIV(T), .INV_BASE(IB), .RESPAWN_TICKS(RT), .LIVES(LV), .SCORE_W(SW)
   ) dut (
      .i_clk_36MHz(clk),
      .i_reset(rst),
      .i_start_debounced(start),
      .i_hit(hit),
      .i_ship_hit(ship),
      .i_invaders_cleared(cleared),
      .i_invaders_landed(landed),
      .o_state(o_state),
      .o_enable(o_enable),
      .o_bullet_tick(o_bullet_tick),
      .o_invader_tick(o_invader_tick),
      .o_wave_start(o_wave_start),
      .o_clear_score(o_clear_score),
      .o_score(o_score),
      .o_lives(o_lives),
      .o_level(o_level)
   );

   int total = 0;
   int bad   = 0;

   // Reference model
   int cyc = 0;
   int m_state = 0, m_score = 0, m_lives = LV, m_level = 0;
   int play_start = 0, resp_start = 0;
   bit m_reload = 0, m_bt = 0, m_it = 0, m_wave = 0, m_clr = 0;

   localparam logic [15:0] RESET_VEC = {2'd0, 5'b00000, 3'd0, 2'(LV), 4'd0};

   task automatic model_step();
      int p;
      cyc++;
      m_bt = 0; m_it = 0; m_wave = 0; m_clr = 0;
      if (rst) begin
         m_state = 0; m_score = 0; m_lives = LV; m_level = 0; m_reload = 0;
      end else begin
         case (m_state)
            0, 3: if (start) begin
               m_state = 1; m_score = 0; m_lives = LV; m_level = 0;
               m_clr = 1; m_wave = 1; play_start = cyc;
            end
            1: begin
               if (hit && m_score < SMAX) m_score++;
               if (landed) m_state = 3;
               else if (ship) begin
                  if (m_lives == 1) begin m_lives = 0; m_state = 3; end
                  else begin m_lives--; m_state = 2; resp_start = cyc; m_reload = 0; end
               end else if (cleared) begin
                  if (m_level < 15) m_level++;
                  m_state = 2; resp_start = cyc; m_reload = 1;
               end else begin
                  p = (IB - m_level > 1) ? IB - m_level : 1;
                  m_bt = ((cyc - play_start) % T == 0);
                  m_it = ((cyc - play_start) % (T * p) == 0);
               end
            end
            2: if (cyc - resp_start == RT * T) begin
               m_state = 1; play_start = cyc; m_wave = m_reload; m_reload = 0;
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [15:0] exp_vec();
      return {2'(m_state), (m_state == 1), m_bt, m_it, m_wave, m_clr,
              SW'(m_score), 2'(m_lives), 4'(m_level)};
   endfunction

   function automatic logic [15:0] obs_vec();
      return {o_state, o_enable, o_bullet_tick, o_invader_tick, o_wave_start,
              o_clear_score, o_score, o_lives, o_level};
   endfunction

   // Drive one cycle of inputs, let the edge happen, advance the model.
   task automatic cycle(input bit s, input bit h, input bit sh, input bit cl,
                        input bit la, input bit rs);
      start = s; hit = h; ship = sh; cleared = cl; landed = la; rst = rs;
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic test_reset();
      cycle(0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 1);
      total++;
      if (obs_vec() !== RESET_VEC) begin
         bad++; $display("FAIL reset_state got=%h want=%h", obs_vec(), RESET_VEC);
      end
      cycle(0, 0, 0, 0, 0, 0);
      total++;
      if (obs_vec() !== exp_vec()) begin
         bad++; $display("FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_start();
      int nb = 0, ni = 0;
      cycle(1, 0, 0, 0, 0, 0);
      total++;
      if ({o_state, o_clear_score, o_wave_start, o_lives} !== {2'd1, 1'b1, 1'b1, 2'd2}) begin
         bad++; $display("FAIL start_edge got st=%0d clr=%0d wave=%0d lives=%0d want 1 1 1 2",
                         o_state, o_clear_score, o_wave_start, o_lives);
      end
      for (int i = 0; i < 24; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL start_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (o_bullet_tick) nb++;
         if (o_invader_tick) ni++;
      end
      total++;
      if (nb != 6 || ni != 2) begin
         bad++; $display("FAIL tick_counts got bullets=%0d invaders=%0d want 6 2", nb, ni);
      end
   endtask

   task automatic test_hits_ship();
      int gap, n_exit = -1, nb = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(0, 1, 0, 0, 0, 0);
         gap = $urandom_range(2);
         for (int g = 0; g < gap; g++) cycle(0, 0, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL hit_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
      end
      cycle(0, 1, 1, 0, 0, 0);
      total++;
      if ({o_score, o_lives, o_state} !== {3'd6, 2'd1, 2'd2}) begin
         bad++; $display("FAIL hit_and_ship got score=%0d lives=%0d st=%0d want 6 1 2",
                         o_score, o_lives, o_state);
      end
      for (int i = 1; i <= 20 && n_exit < 0; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL respawn_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
         if (o_state == 2'd1) n_exit = i;
      end
      total++;
      if (n_exit != RT * T) begin
         bad++; $display("FAIL respawn_len got=%0d want=%0d", n_exit, RT * T);
      end
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         if (o_bullet_tick) nb++;
      end
      total++;
      if (nb != 1 || !o_bullet_tick) begin
         bad++; $display("FAIL resume_tick got bullets=%0d last=%0d want 1 1", nb, o_bullet_tick);
      end
   endtask

   task automatic test_game_over();
      cycle(0, 0, 1, 0, 0, 0);
      total++;
      if ({o_state, o_lives} !== {2'd3, 2'd0}) begin
         bad++; $display("FAIL last_life got st=%0d lives=%0d want 3 0", o_state, o_lives);
      end
      cycle(0, 1, 0, 0, 0, 0);
      total++;
      if (o_score !== 3'd6) begin
         bad++; $display("FAIL over_hit got score=%0d want 6", o_score);
      end
      cycle(1, 0, 0, 0, 0, 0);
      total++;
      if ({o_state, o_lives, o_score, o_level} !== {2'd1, 2'd2, 3'd0, 4'd0}) begin
         bad++; $display("FAIL restart got st=%0d lives=%0d score=%0d level=%0d want 1 2 0 0",
                         o_state, o_lives, o_score, o_level);
      end
   endtask

   task automatic test_levels();
      int nw = 0, nb = 0;
      for (int w = 0; w < 2; w++) begin
         for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
         cycle(0, 0, 0, 1, 0, 0);
         for (int i = 0; i < RT * T; i++) begin
            cycle(0, 0, 0, 0, 0, 0);
            total++;
            if (obs_vec() !== exp_vec()) begin
               bad++; $display("FAIL level_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
            end
            if (o_wave_start) nw++;
         end
      end
      total++;
      if (o_level !== 4'd2 || nw != 2 || o_state !== 2'd1) begin
         bad++; $display("FAIL level_two got level=%0d waves=%0d st=%0d want 2 2 1", o_level, nw, o_state);
      end
      for (int i = 0; i < 16; i++) begin
         cycle(0, 0, 0, 0, 0, 0);
         if (o_bullet_tick) nb++;
         total++;
         if (o_invader_tick !== o_bullet_tick) begin
            bad++; $display("FAIL fast_invader cyc=%0d got inv=%0d want %0d", cyc, o_invader_tick, o_bullet_tick);
         end
      end
      total++;
      if (nb != 4) begin
         bad++; $display("FAIL fast_bullets got=%0d want 4", nb);
      end
   endtask

   task automatic test_landed_reset();
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 1, 0, 1, 0);
      total++;
      if ({o_state, o_lives} !== {2'd3, 2'd2}) begin
         bad++; $display("FAIL landed got st=%0d lives=%0d want 3 2", o_state, o_lives);
      end
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0);
      cycle(1, 1, 1, 0, 1, 1);
      total++;
      if (obs_vec() !== RESET_VEC) begin
         bad++; $display("FAIL mid_reset got=%h want=%h", obs_vec(), RESET_VEC);
      end
   endtask

   task automatic test_saturation();
      cycle(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 1, 0, 0, 0, 0);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL sat_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
      end
      total++;
      if (o_score !== 3'd7) begin
         bad++; $display("FAIL saturate got=%0d want 7", o_score);
      end
   endtask

   task automatic test_random();
      bit s, h, sh, cl, la, rs;
      for (int i = 0; i < 2000; i++) begin
         s  = ($urandom_range(19) == 0);
         h  = ($urandom_range(3) == 0);
         sh = ($urandom_range(39) == 0);
         cl = ($urandom_range(49) == 0);
         la = ($urandom_range(99) == 0);
         rs = ($urandom_range(499) == 0);
         cycle(s, h, sh, cl, la, rs);
         total++;
         if (obs_vec() !== exp_vec()) begin
            bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; hit = 1'b0; ship = 1'b0; cleared = 1'b0; landed = 1'b0;
      test_reset();
      test_start();
      test_hits_ship();
      test_game_over();
      test_levels();
      test_landed_reset();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
